// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl: arbitrates the 16x8 register file's write port and read
// port B between the CPU datapath and a valid/ready debug host. Debug ops
// are accepted only while the CPU is paused and no CPU write is pending.
// Optional feature macro: REGCTRL_R0_ZERO_EN (register 0 reads as constant,
// writes to it are dropped and debug writes to it report an error).
module reg_access_ctrl #(
  parameter int unsigned RF_READ_LAT = 1,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_paused,
  input  logic [ADDR_W-1:0] cpu_ra,
  input  logic [ADDR_W-1:0] cpu_rb,
  input  logic [ADDR_W-1:0] cpu_wa,
  input  logic [DATA_W-1:0] cpu_wd,
  input  logic              cpu_we,
  output logic              cpu_hold,
  input  logic              dbg_req_valid,
  output logic              dbg_req_ready,
  input  logic              dbg_req_write,
  input  logic [ADDR_W-1:0] dbg_req_addr,
  input  logic [DATA_W-1:0] dbg_req_data,
  output logic              dbg_rsp_valid,
  input  logic              dbg_rsp_ready,
  output logic [DATA_W-1:0] dbg_rsp_data,
  output logic              dbg_rsp_err,
  output logic [ADDR_W-1:0] rf_ra,
  output logic [ADDR_W-1:0] rf_rb,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              rf_we,
  input  logic [DATA_W-1:0] rf_read_b
);

  localparam int unsigned CNT_W = (RF_READ_LAT < 1) ? 1 : $clog2(RF_READ_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RF_READ_LAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RSP  = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  lat_cnt;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              req_write;
  logic              accept;
  logic              we_raw;
  logic              wa_ok;
  logic [DATA_W-1:0] wr_rsp_data;

  // Read port A is never contended
  assign rf_ra = cpu_ra;

  // A debug request is taken only in IDLE, with the CPU paused and not writing
  assign dbg_req_ready = (state == IDLE) & cpu_paused & ~cpu_we & ~rst;
  assign accept        = dbg_req_valid & dbg_req_ready;

`ifdef REGCTRL_R0_ZERO_EN
  // Register 0 is constant: drop any write aimed at it
  assign wa_ok       = (rf_wa != '0);
  assign wr_rsp_data = (req_addr == '0) ? '0 : req_data;
`else
  assign wa_ok       = 1'b1;
  assign wr_rsp_data = req_data;
  assign dbg_rsp_err = 1'b0;
`endif

  // Port steering: CPU passthrough in IDLE, latched debug request otherwise
  always_comb begin
    rf_rb  = cpu_rb;
    rf_wa  = cpu_wa;
    rf_wd  = cpu_wd;
    we_raw = cpu_we;
    if (state != IDLE) begin
      rf_rb  = req_addr;
      rf_wa  = req_addr;
      rf_wd  = req_data;
      we_raw = (state == WR);
    end
  end

  // No write may reach the register file during a reset cycle
  assign rf_we = we_raw & wa_ok & ~rst;

  // Controller FSM with registered response and hold outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lat_cnt       <= '0;
      req_addr      <= '0;
      req_data      <= '0;
      req_write     <= 1'b0;
      cpu_hold      <= 1'b0;
      dbg_rsp_valid <= 1'b0;
      dbg_rsp_data  <= '0;
`ifdef REGCTRL_R0_ZERO_EN
      dbg_rsp_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_addr  <= dbg_req_addr;
            req_data  <= dbg_req_data;
            req_write <= dbg_req_write;
            lat_cnt   <= '0;
            cpu_hold  <= 1'b1;
            state     <= dbg_req_write ? WR : RD;
          end
        end
        WR: begin
          dbg_rsp_data  <= wr_rsp_data;
`ifdef REGCTRL_R0_ZERO_EN
          dbg_rsp_err   <= (req_addr == '0);
`endif
          dbg_rsp_valid <= 1'b1;
          state         <= RSP;
        end
        RD: begin
          if (lat_cnt == LAT_LAST) begin
            dbg_rsp_data  <= rf_read_b;
`ifdef REGCTRL_R0_ZERO_EN
            dbg_rsp_err   <= 1'b0;
`endif
            dbg_rsp_valid <= 1'b1;
            state         <= RSP;
          end else begin
            lat_cnt <= lat_cnt + CNT_W'(1);
          end
        end
        RSP: begin
          if (dbg_rsp_ready) begin
            dbg_rsp_valid <= 1'b0;
            cpu_hold      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Bench for reg_access_ctrl: a 16x8 register file with a one-cycle read
// port B is attached to the controller; an array model of its contents
// predicts every debug response. Define REGCTRL_R0_ZERO_EN for both
// files to exercise the constant-register-0 variant.
module tb_reg_access_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned RD_LAT = 1;
`ifdef REGCTRL_R0_ZERO_EN
  localparam bit R0_EN = 1'b1;
`else
  localparam bit R0_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_paused, cpu_we, cpu_hold;
  logic [AW-1:0] cpu_ra, cpu_rb, cpu_wa;
  logic [DW-1:0] cpu_wd;
  logic          dbg_req_valid, dbg_req_ready, dbg_req_write;
  logic [AW-1:0] dbg_req_addr;
  logic [DW-1:0] dbg_req_data;
  logic          dbg_rsp_valid, dbg_rsp_ready, dbg_rsp_err;
  logic [DW-1:0] dbg_rsp_data;
  logic [AW-1:0] rf_ra, rf_rb, rf_wa;
  logic [DW-1:0] rf_wd, rf_read_b;
  logic          rf_we;

  logic [DW-1:0] rf_mem [16];
  logic [DW-1:0] model  [16];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reg_access_ctrl #(.RF_READ_LAT(RD_LAT), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .cpu_paused(cpu_paused),
    .cpu_ra(cpu_ra), .cpu_rb(cpu_rb), .cpu_wa(cpu_wa), .cpu_wd(cpu_wd),
    .cpu_we(cpu_we), .cpu_hold(cpu_hold),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
    .dbg_req_write(dbg_req_write), .dbg_req_addr(dbg_req_addr),
    .dbg_req_data(dbg_req_data), .dbg_rsp_valid(dbg_rsp_valid),
    .dbg_rsp_ready(dbg_rsp_ready), .dbg_rsp_data(dbg_rsp_data),
    .dbg_rsp_err(dbg_rsp_err), .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_wa(rf_wa),
    .rf_wd(rf_wd), .rf_we(rf_we), .rf_read_b(rf_read_b)
  );

  // Register file: synchronous write, one-cycle registered read port B
  always @(posedge clk) begin
    rf_read_b <= rf_mem[rf_rb];
    if (rf_we) rf_mem[rf_wa] <= rf_wd;
  end

  // True when a write to this address is allowed to land
  function automatic logic wr_ok(input logic [AW-1:0] a);
    return (a != 4'd0) || !R0_EN;
  endfunction

  task automatic rand_cpu();
    cpu_ra = 4'($urandom); cpu_rb = 4'($urandom);
    cpu_wa = 4'($urandom); cpu_wd = 8'($urandom);
  endtask

  // One complete debug op from accept to response handshake, checked cycle by cycle
  task automatic run_dbg_op(input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input int hold, input int drop_k);
    int lat;
    logic exp_we, exp_err;
    logic [DW-1:0] exp_data;
    lat      = wr ? 2 : int'(RD_LAT) + 2;
    exp_we   = wr && wr_ok(a);
    exp_err  = wr && !wr_ok(a);
    exp_data = wr ? (exp_err ? 8'h00 : d) : model[a];
    @(negedge clk);
    rand_cpu(); cpu_paused = 1'b1; cpu_we = 1'b0;
    dbg_req_valid = 1'b1; dbg_req_write = wr; dbg_req_addr = a; dbg_req_data = d;
    dbg_rsp_ready = 1'b0;
    #1;
    vectors++;
    if ({dbg_req_ready, cpu_hold} !== 2'b10) begin
      miscompares++; $display("FAIL accept: ready/hold got %b want 10", {dbg_req_ready, cpu_hold});
    end
    for (int k = 1; k <= lat + hold; k++) begin
      @(negedge clk);
      rand_cpu(); cpu_we = 1'($urandom);
      dbg_req_valid = 1'($urandom); dbg_req_write = 1'($urandom);
      dbg_req_addr = 4'($urandom); dbg_req_data = 8'($urandom);
      if (k == drop_k) cpu_paused = 1'b0;
      dbg_rsp_ready = (k == lat + hold);
      #1;
      vectors++;
      if ({cpu_hold, dbg_req_ready} !== 2'b10) begin
        miscompares++; $display("FAIL busy k=%0d: hold/ready got %b want 10", k, {cpu_hold, dbg_req_ready});
      end
      vectors++;
      if (wr && k == 1) begin
        if ({rf_we, rf_wa, rf_wd} !== {exp_we, a, d}) begin
          miscompares++; $display("FAIL wr_port: we/wa/wd got %b/%h/%h want %b/%h/%h", rf_we, rf_wa, rf_wd, exp_we, a, d);
        end
      end else if (rf_we !== 1'b0) begin
        miscompares++; $display("FAIL stray_we k=%0d: rf_we got %b want 0", k, rf_we);
      end
      if (!wr && k <= int'(RD_LAT) + 1) begin
        vectors++;
        if (rf_rb !== a) begin
          miscompares++; $display("FAIL rd_port k=%0d: rf_rb got %h want %h", k, rf_rb, a);
        end
      end
      vectors++;
      if (k < lat) begin
        if (dbg_rsp_valid !== 1'b0) begin
          miscompares++; $display("FAIL early_rsp k=%0d: rsp_valid got %b want 0", k, dbg_rsp_valid);
        end
      end else if ({dbg_rsp_valid, dbg_rsp_err, dbg_rsp_data} !== {1'b1, exp_err, exp_data}) begin
        miscompares++; $display("FAIL rsp k=%0d a=%h: valid/err/data got %b/%b/%h want 1/%b/%h",
                                k, a, dbg_rsp_valid, dbg_rsp_err, dbg_rsp_data, exp_err, exp_data);
      end
    end
    if (exp_we) model[a] = d;
    @(negedge clk);
    rand_cpu(); cpu_paused = 1'b0; cpu_we = 1'b0;
    dbg_req_valid = 1'b0; dbg_rsp_ready = 1'b0;
    #1;
    vectors++;
    if ({dbg_rsp_valid, cpu_hold, rf_wa, rf_rb} !== {2'b00, cpu_wa, cpu_rb}) begin
      miscompares++; $display("FAIL release: valid/hold/wa/rb got %b/%b/%h/%h want 0/0/%h/%h",
                              dbg_rsp_valid, cpu_hold, rf_wa, rf_rb, cpu_wa, cpu_rb);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({cpu_hold, dbg_rsp_valid, dbg_rsp_err, rf_we, dbg_req_ready} !== 5'b0) begin
      miscompares++; $display("FAIL reset_ctl: hold/valid/err/we/ready got %b want 00000",
                              {cpu_hold, dbg_rsp_valid, dbg_rsp_err, rf_we, dbg_req_ready});
    end
    vectors++;
    if (dbg_rsp_data !== 8'h00) begin
      miscompares++; $display("FAIL reset_data: got %h want 00", dbg_rsp_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_passthrough();
    logic exp_we;
    @(negedge clk);
    rand_cpu(); cpu_paused = 1'b0; cpu_we = 1'b1; cpu_wa = 4'd5; cpu_wd = 8'h55;
    dbg_req_valid = 1'b1;
    #1;
    vectors++;
    if ({rf_we, rf_wa, rf_wd, dbg_req_ready} !== {1'b1, 4'd5, 8'h55, 1'b0}) begin
      miscompares++; $display("FAIL pass_w5: we/wa/wd/ready got %b/%h/%h/%b want 1/5/55/0", rf_we, rf_wa, rf_wd, dbg_req_ready);
    end
    model[5] = 8'h55;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      rand_cpu(); cpu_we = 1'($urandom); dbg_req_valid = 1'($urandom);
      #1;
      exp_we = cpu_we && wr_ok(cpu_wa);
      vectors++;
      if ({rf_ra, rf_rb, rf_wa, rf_wd, rf_we, dbg_req_ready, cpu_hold} !==
          {cpu_ra, cpu_rb, cpu_wa, cpu_wd, exp_we, 2'b00}) begin
        miscompares++; $display("FAIL pass_rand %0d: ra/rb/wa/wd/we got %h/%h/%h/%h/%b want %h/%h/%h/%h/%b",
                                i, rf_ra, rf_rb, rf_wa, rf_wd, rf_we, cpu_ra, cpu_rb, cpu_wa, cpu_wd, exp_we);
      end
      if (exp_we) model[cpu_wa] = cpu_wd;
    end
  endtask

  task automatic test_dbg_write();
    run_dbg_op(1'b1, 4'd3, 8'hAA, 0, 0);
    run_dbg_op(1'b0, 4'd3, 8'($urandom), 0, 0);
  endtask

  task automatic test_dbg_read();
    @(negedge clk);
    rand_cpu(); cpu_paused = 1'b0; cpu_we = 1'b1; cpu_wa = 4'd9; cpu_wd = 8'h99;
    model[9] = 8'h99;
    run_dbg_op(1'b0, 4'd9, 8'h00, 0, 0);
  endtask

  task automatic test_backpressure();
    run_dbg_op(1'b0, 4'd9, 8'h00, 4, 0);
    run_dbg_op(1'b1, 4'd7, 8'h3C, 4, 0);
  endtask

  task automatic test_cpu_priority();
    logic exp_we;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rand_cpu(); cpu_paused = 1'b1; cpu_we = 1'b1; cpu_wa = 4'd6 + 4'(i);
      dbg_req_valid = 1'b1; dbg_req_write = 1'b0; dbg_req_addr = 4'd6;
      #1;
      exp_we = wr_ok(cpu_wa);
      vectors++;
      if ({dbg_req_ready, cpu_hold, rf_we, rf_wd} !== {2'b00, exp_we, cpu_wd}) begin
        miscompares++; $display("FAIL cpu_wins %0d: ready/hold/we/wd got %b/%b/%b/%h want 0/0/%b/%h",
                                i, dbg_req_ready, cpu_hold, rf_we, rf_wd, exp_we, cpu_wd);
      end
      if (exp_we) model[cpu_wa] = cpu_wd;
    end
    run_dbg_op(1'b0, 4'd6, 8'h00, 0, 0);
  endtask

  task automatic test_drop_paused();
    run_dbg_op(1'b0, 4'd5, 8'h00, 1, 1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 30; i++)
      run_dbg_op(1'($urandom), 4'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 0);
  endtask

  task automatic test_reset_mid_op();
    logic [AW-1:0] a;
    a = 4'($urandom_range(1, 15));
    // reset while the write strobe would be issued
    @(negedge clk);
    cpu_paused = 1'b1; cpu_we = 1'b0; dbg_req_valid = 1'b1; dbg_req_write = 1'b1;
    dbg_req_addr = a; dbg_req_data = ~model[a]; dbg_rsp_ready = 1'b0;
    @(negedge clk);
    dbg_req_valid = 1'b0; rst = 1'b1;
    #1;
    vectors++;
    if (rf_we !== 1'b0) begin
      miscompares++; $display("FAIL rst_wr: rf_we got %b want 0", rf_we);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if ({dbg_rsp_valid, cpu_hold} !== 2'b00) begin
      miscompares++; $display("FAIL rst_wr_abort: valid/hold got %b want 00", {dbg_rsp_valid, cpu_hold});
    end
    run_dbg_op(1'b0, a, 8'h00, 0, 0);
    // reset while the response is waiting
    @(negedge clk);
    cpu_paused = 1'b1; cpu_we = 1'b0; dbg_req_valid = 1'b1; dbg_req_write = 1'b0;
    dbg_req_addr = a; dbg_rsp_ready = 1'b0;
    for (int k = 1; k <= int'(RD_LAT) + 2; k++) begin
      @(negedge clk);
      dbg_req_valid = 1'b0;
    end
    #1;
    vectors++;
    if (dbg_rsp_valid !== 1'b1) begin
      miscompares++; $display("FAIL rst_rsp_pre: rsp_valid got %b want 1", dbg_rsp_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if ({dbg_rsp_valid, cpu_hold, dbg_rsp_err, dbg_rsp_data} !== {3'b000, 8'h00}) begin
      miscompares++; $display("FAIL rst_rsp: valid/hold/err/data got %b/%b/%b/%h want 0/0/0/00",
                              dbg_rsp_valid, cpu_hold, dbg_rsp_err, dbg_rsp_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_r0();
    logic exp_we;
    @(negedge clk);
    rand_cpu(); cpu_paused = 1'b0; cpu_we = 1'b1; cpu_wa = 4'd0; cpu_wd = 8'h42;
    #1;
    exp_we = wr_ok(4'd0);
    vectors++;
    if (rf_we !== exp_we) begin
      miscompares++; $display("FAIL r0_cpu: rf_we got %b want %b", rf_we, exp_we);
    end
    if (exp_we) model[0] = 8'h42;
    run_dbg_op(1'b1, 4'd0, 8'h7F, 0, 0);
    run_dbg_op(1'b0, 4'd0, 8'h00, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      rf_mem[i] = 8'h00;
      model[i]  = 8'h00;
    end
    rf_read_b = 8'h00;
    rst = 1'b1; cpu_paused = 1'b0; cpu_we = 1'b0;
    cpu_ra = '0; cpu_rb = '0; cpu_wa = '0; cpu_wd = '0;
    dbg_req_valid = 1'b0; dbg_req_write = 1'b0; dbg_req_addr = '0; dbg_req_data = '0;
    dbg_rsp_ready = 1'b0;
    test_reset();
    test_passthrough();
    test_dbg_write();
    test_dbg_read();
    test_backpressure();
    test_cpu_priority();
    test_drop_paused();
    test_back_to_back();
    test_reset_mid_op();
    test_r0();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
